// File: rtl/m_mem_arbiter.sv
// ============================================================================
// Module   : m_mem_arbiter
// Purpose  : Single-port memory arbiter sharing one memory between fetch and
//            data stages; data priority with a bounded fetch starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_mem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_if_req,
    input  logic [31:0] w_if_adr,
    output logic        w_if_gnt,
    output logic        w_if_vld,
    output logic [31:0] w_if_rdata,
    input  logic        w_d_req,
    input  logic        w_d_we,
    input  logic [31:0] w_d_adr,
    input  logic [31:0] w_d_wdata,
    output logic        w_d_gnt,
    output logic        w_d_vld,
    output logic [31:0] w_d_rdata,
    output logic        w_m_en,
    output logic        w_m_we,
    output logic [31:0] w_m_adr,
    output logic [31:0] w_m_wdata,
    input  logic [31:0] w_m_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] c_CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    state_t     r_busy;
    state_t     w_busy_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_own;
    logic       w_own_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;

    logic       w_accept;
    logic       w_if_win;
    logic       w_d_win;
    logic       w_grant;
    logic       w_resp;

    // The last latency cycle doubles as the next accept window.
    assign w_accept = (r_busy == ST_IDLE) || (r_cnt == 4'd0);

    assign w_if_win = w_rst_n && w_accept && w_if_req &&
                      (!w_d_req || (r_starve == c_STARVE_MAX));
    assign w_d_win  = w_rst_n && w_accept && w_d_req && !w_if_win;
    assign w_grant  = w_if_win || w_d_win;

    assign w_if_gnt  = w_if_win;
    assign w_d_gnt   = w_d_win;
    assign w_m_en    = w_grant;
    assign w_m_we    = w_d_win && w_d_we;
    assign w_m_adr   = w_d_win ? w_d_adr : w_if_adr;
    assign w_m_wdata = w_d_wdata;

    assign w_resp     = (r_busy == ST_BUSY) && (r_cnt == 4'd0);
    assign w_if_vld   = w_resp && !r_own;
    assign w_d_vld    = w_resp && r_own;
    assign w_if_rdata = w_m_rdata;
    assign w_d_rdata  = w_m_rdata;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy   <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_own    <= 1'b0;
            r_starve <= 4'd0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_cnt    <= w_cnt_nxt;
            r_own    <= w_own_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_busy_nxt   = r_busy;
        w_cnt_nxt    = r_cnt;
        w_own_nxt    = r_own;
        w_starve_nxt = r_starve;

        if (w_grant) begin
            w_busy_nxt = ST_BUSY;
            w_cnt_nxt  = c_CNT_LOAD;
            w_own_nxt  = w_d_win;
        end else if (r_busy == ST_BUSY) begin
            if (r_cnt != 4'd0) begin
                w_cnt_nxt = r_cnt - 4'd1;
            end else begin
                w_busy_nxt = ST_IDLE;
            end
        end

        // Saturating guard keeps the counter bounded even if req timing misbehaves.
        if (w_if_win) begin
            w_starve_nxt = 4'd0;
        end else if (w_d_win && w_if_req && (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: doc/m_mem_arbiter.md
# m_mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage (IF) and the memory-access stage (MA) of the pipelined core. It accepts one request per accept window, drives the memory command for exactly one cycle, counts a fixed access latency, and routes the response back to the owning requester. The policy is data-priority with a starvation bound on fetch. The block sits between the IF/MA stages and the memory array, and replaces their separate memory instances.

## Interface
- LATENCY, 2: cycles from command (cycle T) to valid read data (cycle T+LATENCY); legal range 1..15.
- STARVE_MAX, 4: maximum consecutive data grants that may be given while fetch is waiting; legal range 1..15.

- w_clk  in  1  clock, rising edge.
- w_rst_n  in  1  asynchronous, active-low reset.
- w_if_req  in  1  fetch request; held with w_if_adr stable until w_if_gnt.
- w_if_adr  in  32  fetch byte address.
- w_if_gnt  out  1  one-cycle grant to fetch.
- w_if_vld  out  1  fetch response valid.
- w_if_rdata  out  32  fetch read data.
- w_d_req  in  1  data request; held with w_d_we, w_d_adr and w_d_wdata stable until w_d_gnt.
- w_d_we  in  1  1 = store, 0 = load.
- w_d_adr  in  32  data byte address.
- w_d_wdata  in  32  store data.
- w_d_gnt  out  1  one-cycle grant to data.
- w_d_vld  out  1  data response valid (load data or store completion).
- w_d_rdata  out  32  load data.
- w_m_en  out  1  memory command strobe.
- w_m_we  out  1  memory write enable.
- w_m_adr  out  32  memory byte address, passed through unchanged.
- w_m_wdata  out  32  memory write data.
- w_m_rdata  in  32  memory read data, valid in cycle T+LATENCY.

## Operation
- State: r_busy (IDLE/BUSY), r_cnt (4 bits), r_own (0 = fetch, 1 = data), r_starve (4 bits).
- Accept window: the arbiter is in an accept window when r_busy = 0, or when r_busy = 1 and r_cnt = 0.
- Grant decision (combinational, only inside an accept window and only while w_rst_n = 1):
  - If only one request is present, that requester wins.
  - If both are present, data wins unless r_starve = STARVE_MAX, in which case fetch wins.
- Memory command on grant:
  - w_m_en = 1 in the grant cycle only.
  - w_m_we, w_m_adr and w_m_wdata are muxed from the winner.
  - A fetch grant forces w_m_we = 0.
- Memory outputs when there is no grant: w_m_en = 0 and w_m_we = 0. w_m_adr and w_m_wdata are don't-care.
- Update at the clock edge ending a grant cycle:
  - r_busy ← 1, r_cnt ← LATENCY-1, r_own ← winner.
- Update at the clock edge ending a no-grant cycle:
  - If r_busy = 1 and r_cnt ≠ 0: r_cnt decrements.
  - If r_busy = 1 and r_cnt = 0: r_busy ← 0.
- Response:
  - w_if_vld = r_busy & (r_cnt = 0) & ~r_own.
  - w_d_vld = r_busy & (r_cnt = 0) & r_own.
  - w_if_rdata and w_d_rdata = w_m_rdata (pass-through). They are meaningful only while the corresponding vld is high and, for data, only on a load.
  - A store gets a w_d_vld pulse as its completion; its rdata is undefined.
- Starvation counter r_starve:
  - Cleared to 0 on any fetch grant.
  - Incremented on a data grant given while w_if_req = 1.
  - Held otherwise.
  - Never exceeds STARVE_MAX.
- At most one access is outstanding. A new grant may coincide with the previous response cycle.

## Timing
- Reset (w_rst_n = 0, asynchronous): r_busy = 0, r_cnt = 0, r_own = 0, r_starve = 0.
- Output values while in reset: w_if_gnt = w_d_gnt = 0, w_m_en = w_m_we = 0, w_if_vld = w_d_vld = 0.
- Latency: grant in cycle T gives vld in cycle T+LATENCY.
- Throughput: one access every LATENCY cycles. With LATENCY = 1, one access per cycle.
- A requester must not drop req before gnt. Behaviour when req drops early is undefined, but the FSM must remain consistent.
- Simultaneous response and new grant (r_cnt = 0 while in BUSY): the vld for the old owner and the gnt for the new winner both assert in the same cycle.
- Reset mid-access: the in-flight response is discarded and no vld follows deassertion. The first cycle after deassertion is an IDLE accept window.

## Test plan
- Reset: hold w_rst_n = 0 with both req = 1 → gnt, w_m_en and vld all stay 0. Deassert → data granted in the first cycle.
- Single fetch (LATENCY = 2): w_if_req = 1, w_if_adr = 0x10 in cycle 0 → w_if_gnt = w_m_en = 1 and w_m_adr = 0x10 in cycle 0; w_if_vld = 1 in cycle 2 with w_if_rdata = mem[0x10>>2]. No w_d_vld at any point.
- Store then load (LATENCY = 2): store 0xDEADBEEF to 0x40 at cycle 0 → w_m_we = 1 in cycle 0, w_d_vld in cycle 2. Load 0x40 granted in cycle 2 → w_d_vld in cycle 4 with w_d_rdata = 0xDEADBEEF.
- Contention (STARVE_MAX = 4, LATENCY = 1): both req held high continuously → grant sequence D D D D F D D D D F. r_starve returns to 0 after each F.
- Reset mid-access (LATENCY = 3): grant at cycle 0, w_rst_n low during cycle 1 → no vld in cycle 3. After release, a new fetch completes normally 3 cycles after its grant.
- Back-to-back (LATENCY = 1): w_if_req held high with addresses 0, 4, 8 → gnt every cycle and vld every cycle one cycle later, with matching data.
